// File: rtl/counter_enable_seq_pkg.sv
// Shared constants for the enable sequencer: FSM state encoding and default widths.
package counter_enable_seq_pkg;

   localparam int CNT_W_DEF = 8;
   localparam int PRE_W_DEF = 4;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_PAUSED = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/counter_enable_seq_if.sv
// Control/status bundle between a run issuer (master) and the enable sequencer (slave).
interface counter_enable_seq_if
   import counter_enable_seq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int PRE_W = PRE_W_DEF
);

   logic             start;
   logic             stop;
   logic             pause;
   logic [CNT_W-1:0] run_len;
   logic [PRE_W-1:0] prescale;
   logic             enable;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] cycles_left;

   modport master (
      output start, stop, pause, run_len, prescale,
      input  enable, busy, done, cycles_left
   );

   modport slave (
      input  start, stop, pause, run_len, prescale,
      output enable, busy, done, cycles_left
   );

endinterface

// File: rtl/counter_enable_seq_enable_prescaler.sv
// Pulse spacing counter: tick is high when the phase counter reaches the latched
// prescale value; advancing on a tick wraps the phase back to zero.
module enable_prescaler #(
   parameter int PRE_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             hold,
   input  logic             advance,
   input  logic [PRE_W-1:0] lat_val,
   output logic             tick
);

   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [PRE_W-1:0] pre_lat_q, pre_lat_d;

   assign tick = (pre_cnt_q == pre_lat_q);

   // Next-phase selection: load restarts the phase, hold freezes it, advance steps or wraps.
   always_comb begin
      pre_cnt_d = pre_cnt_q;
      pre_lat_d = pre_lat_q;
      if (load) begin
         pre_cnt_d = '0;
         pre_lat_d = lat_val;
      end else if (!hold && advance) begin
         if (tick) pre_cnt_d = '0;
         else      pre_cnt_d = pre_cnt_q + PRE_W'(1);
      end
   end

   // Phase and latched-prescale registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pre_cnt_q <= '0;
         pre_lat_q <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
         pre_lat_q <= pre_lat_d;
      end
   end

endmodule

// File: rtl/counter_enable_seq.sv
// Burst generator for a downstream counter's enable: issues exactly run_len pulses
// spaced prescale+1 cycles apart, with pause/resume/stop and a one-cycle done pulse.
module counter_enable_seq
   import counter_enable_seq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int PRE_W = PRE_W_DEF
) (
   input logic                 clock,
   input logic                 reset,
   counter_enable_seq_if.slave bus
);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic             pre_load, pre_hold, pre_adv;
   logic             tick;
   logic             enable_w;

   enable_prescaler #(.PRE_W(PRE_W)) u_prescaler (
      .clock   (clock),
      .reset   (reset),
      .load    (pre_load),
      .hold    (pre_hold),
      .advance (pre_adv),
      .lat_val (bus.prescale),
      .tick    (tick)
   );

   // Enable depends on registered state only, so no input reaches it combinationally.
   assign enable_w        = (state_q == ST_RUN) && tick;
   assign bus.enable      = enable_w;
   assign bus.busy        = (state_q == ST_RUN) || (state_q == ST_PAUSED);
   assign bus.done        = (state_q == ST_DONE);
   assign bus.cycles_left = remaining_q;

   // Run control FSM and remaining-pulse bookkeeping.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      pre_load    = 1'b0;
      pre_hold    = 1'b1;
      pre_adv     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start && (bus.run_len != '0)) begin
               state_d     = ST_RUN;
               remaining_d = bus.run_len;
               pre_load    = 1'b1;
            end
         end
         ST_RUN: begin
            if (bus.stop) begin
               state_d     = ST_IDLE;
               remaining_d = '0;
            end else if (enable_w) begin
               // The pulse in this cycle reaches the counter even when pause is
               // sampled now, so it is always counted and its phase consumed.
               remaining_d = remaining_q - CNT_W'(1);
               pre_hold    = 1'b0;
               pre_adv     = 1'b1;
               if (remaining_q == CNT_W'(1)) state_d = ST_DONE;
               else if (bus.pause)           state_d = ST_PAUSED;
            end else if (bus.pause) begin
               state_d = ST_PAUSED;
            end else begin
               pre_hold = 1'b0;
               pre_adv  = 1'b1;
            end
         end
         ST_PAUSED: begin
            if (bus.stop) begin
               state_d     = ST_IDLE;
               remaining_d = '0;
            end else if (!bus.pause) begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d     = ST_IDLE;
            remaining_d = '0;
         end
      endcase
   end

   // State and remaining-count registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
      end
   end

endmodule

// File: tb/tb_counter_enable_seq.sv
// Directed bench for the enable sequencer, with a 4-bit downstream counter model.
module tb_counter_enable_seq;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   pulses = 0;
   logic [3:0] first_cnt;

   counter_enable_seq_if #(.CNT_W(8), .PRE_W(4)) bus ();

   counter_enable_seq #(.CNT_W(8), .PRE_W(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Downstream first_counter and a running total of enable pulses seen.
   always @(posedge clock or posedge reset) begin
      if (reset) first_cnt <= 4'd0;
      else if (bus.enable) first_cnt <= first_cnt + 4'd1;
   end
   always @(posedge clock) if (!reset && bus.enable) pulses <= pulses + 1;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      bus.start = 0; bus.stop = 0; bus.pause = 0; bus.run_len = 8'd0; bus.prescale = 4'd0;
      #2;
      checks++;
      if ({bus.enable, bus.busy, bus.done} !== 3'b000 || bus.cycles_left !== 8'd0) begin
         errors++;
         $display("FAIL reset_outputs got en/busy/done=%b%b%b left=%0d exp 000 left=0",
                  bus.enable, bus.busy, bus.done, bus.cycles_left);
      end
      step(); step();
      reset = 0;
      step();
      checks++;
      if (bus.busy !== 1'b0 || first_cnt !== 4'd0) begin
         errors++;
         $display("FAIL reset_idle got busy=%b cnt=%0d exp busy=0 cnt=0", bus.busy, first_cnt);
      end
   endtask

   task automatic test_burst_p0();
      bus.start = 1; bus.run_len = 8'd5; bus.prescale = 4'd0;
      step();
      bus.start = 0;
      for (int c = 1; c <= 5; c++) begin
         checks++;
         if (bus.enable !== 1'b1 || bus.busy !== 1'b1 || bus.cycles_left !== 8'(6 - c)) begin
            errors++;
            $display("FAIL p0_cycle%0d got en=%b busy=%b left=%0d exp en=1 busy=1 left=%0d",
                     c, bus.enable, bus.busy, bus.cycles_left, 6 - c);
         end
         step();
      end
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.enable !== 1'b0) begin
         errors++;
         $display("FAIL p0_done got done=%b busy=%b en=%b exp 1 0 0", bus.done, bus.busy, bus.enable);
      end
      step();
      checks++;
      if (bus.done !== 1'b0 || first_cnt !== 4'b0101) begin
         errors++;
         $display("FAIL p0_counter got done=%b cnt=%b exp done=0 cnt=0101", bus.done, first_cnt);
      end
   endtask

   task automatic test_prescale();
      bus.start = 1; bus.run_len = 8'd3; bus.prescale = 4'd2;
      step();
      bus.start = 0;
      for (int c = 1; c <= 9; c++) begin
         checks++;
         if (bus.enable !== ((c % 3) == 0) || bus.cycles_left !== 8'(3 - (c - 1) / 3)) begin
            errors++;
            $display("FAIL pre_cycle%0d got en=%b left=%0d exp en=%0d left=%0d",
                     c, bus.enable, bus.cycles_left, (c % 3) == 0, 3 - (c - 1) / 3);
         end
         step();
      end
      checks++;
      if (bus.done !== 1'b1 || bus.cycles_left !== 8'd0) begin
         errors++;
         $display("FAIL pre_done got done=%b left=%0d exp done=1 left=0", bus.done, bus.cycles_left);
      end
      step();
   endtask

   task automatic test_pause();
      int base;
      base = pulses;
      bus.start = 1; bus.run_len = 8'd6; bus.prescale = 4'd0;
      step();
      bus.start = 0;
      step(); step();
      bus.pause = 1;
      checks++;
      if (bus.enable !== 1'b1) begin
         errors++;
         $display("FAIL pause_sample_pulse got en=%b exp 1", bus.enable);
      end
      step();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (bus.enable !== 1'b0 || bus.cycles_left !== 8'd3 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL pause_hold%0d got en=%b left=%0d busy=%b exp en=0 left=3 busy=1",
                     k, bus.enable, bus.cycles_left, bus.busy);
         end
         if (k == 3) bus.pause = 0;
         step();
      end
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (bus.enable !== 1'b1 || bus.cycles_left !== 8'(3 - c)) begin
            errors++;
            $display("FAIL resume%0d got en=%b left=%0d exp en=1 left=%0d",
                     c, bus.enable, bus.cycles_left, 3 - c);
         end
         step();
      end
      checks++;
      if (bus.done !== 1'b1 || (pulses - base) !== 6) begin
         errors++;
         $display("FAIL pause_total got done=%b pulses=%0d exp done=1 pulses=6", bus.done, pulses - base);
      end
      step();
   endtask

   task automatic test_stop();
      int base;
      logic seen_done;
      base = pulses;
      seen_done = 0;
      bus.start = 1; bus.run_len = 8'd8; bus.prescale = 4'd0;
      step();
      bus.start = 0;
      step(); step(); step();
      bus.stop = 1;
      checks++;
      if (bus.enable !== 1'b1) begin
         errors++;
         $display("FAIL stop_sample_pulse got en=%b exp 1", bus.enable);
      end
      step();
      bus.stop = 0;
      checks++;
      if (bus.busy !== 1'b0 || bus.enable !== 1'b0 || bus.cycles_left !== 8'd0) begin
         errors++;
         $display("FAIL stop_idle got busy=%b en=%b left=%0d exp 0 0 0", bus.busy, bus.enable, bus.cycles_left);
      end
      for (int k = 0; k < 4; k++) begin
         if (bus.done) seen_done = 1;
         step();
      end
      checks++;
      if (seen_done !== 1'b0 || (pulses - base) !== 4) begin
         errors++;
         $display("FAIL stop_total got done_seen=%b pulses=%0d exp done_seen=0 pulses=4",
                  seen_done, pulses - base);
      end
   endtask

   task automatic test_ignored_start();
      int base;
      bus.start = 1; bus.run_len = 8'd0; bus.prescale = 4'd0;
      step(); step();
      checks++;
      if (bus.busy !== 1'b0 || bus.enable !== 1'b0) begin
         errors++;
         $display("FAIL zero_len_start got busy=%b en=%b exp 0 0", bus.busy, bus.enable);
      end
      base = pulses;
      bus.run_len = 8'd4;
      step();
      bus.run_len = 8'd2;
      for (int c = 1; c <= 4; c++) begin
         checks++;
         if (bus.enable !== 1'b1 || bus.cycles_left !== 8'(5 - c)) begin
            errors++;
            $display("FAIL busy_start%0d got en=%b left=%0d exp en=1 left=%0d",
                     c, bus.enable, bus.cycles_left, 5 - c);
         end
         step();
      end
      checks++;
      if (bus.done !== 1'b1) begin
         errors++;
         $display("FAIL busy_start_done got done=%b exp 1", bus.done);
      end
      step();
      checks++;
      if (bus.busy !== 1'b0 || (pulses - base) !== 4) begin
         errors++;
         $display("FAIL busy_start_total got busy=%b pulses=%0d exp busy=0 pulses=4", bus.busy, pulses - base);
      end
      bus.start = 0;
      step();
   endtask

   task automatic test_async_reset();
      bus.start = 1; bus.run_len = 8'd8; bus.prescale = 4'd0;
      step();
      bus.start = 0;
      step();
      #2;
      reset = 1;
      #1;
      checks++;
      if (bus.enable !== 1'b0 || bus.busy !== 1'b0 || bus.cycles_left !== 8'd0) begin
         errors++;
         $display("FAIL async_reset got en=%b busy=%b left=%0d exp 0 0 0", bus.enable, bus.busy, bus.cycles_left);
      end
      step();
      reset = 0;
      step();
      bus.start = 1; bus.run_len = 8'd2; bus.prescale = 4'd1;
      step();
      bus.start = 0;
      for (int c = 1; c <= 4; c++) begin
         checks++;
         if (bus.enable !== ((c % 2) == 0) || bus.cycles_left !== 8'(2 - (c - 1) / 2)) begin
            errors++;
            $display("FAIL post_reset%0d got en=%b left=%0d exp en=%0d left=%0d",
                     c, bus.enable, bus.cycles_left, (c % 2) == 0, 2 - (c - 1) / 2);
         end
         step();
      end
      checks++;
      if (bus.done !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_done got done=%b exp 1", bus.done);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_burst_p0();
      test_prescale();
      test_pause();
      test_stop();
      test_ignored_start();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
